// File: rtl/l2_req_arbiter.sv
// l2_req_arbiter
// Round-robin arbiter and invalidate sequencer in front of the shared L2
// native port. Up to N_MASTERS requesters (I-cache / D-cache back-ends) are
// multiplexed onto one L2 port. A grant is held until the L2 answers, and
// L2 invalidation is strobed only while no transaction is in flight.
//
// Ports
//   clk          : single clock, rising-edge
//   rst          : asynchronous reset, active low
//   m_valid      : per-master request valid, held until the matching m_ready
//   m_addr       : per-master address, master i at [i*ADDR_W +: ADDR_W]
//   m_wdata      : per-master write data, master i at [i*DATA_W +: DATA_W]
//   m_wstrb      : per-master write strobe (all zero = read)
//   m_rdata      : L2 read data broadcast to every master
//   m_ready      : per-master completion pulse
//   s_valid      : L2 request valid
//   s_addr       : L2 request address
//   s_wdata      : L2 request write data
//   s_wstrb      : L2 request write strobe
//   s_rdata      : L2 read data
//   s_ready      : L2 completion pulse
//   inv_req      : invalidate request (pulse or level)
//   s_force_inv  : one-cycle invalidate strobe to the L2
//   busy         : grant held or invalidate still pending
module l2_req_arbiter #(
   parameter int N_MASTERS = 2,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [N_MASTERS-1:0]            m_valid,
   input  logic [N_MASTERS*ADDR_W-1:0]     m_addr,
   input  logic [N_MASTERS*DATA_W-1:0]     m_wdata,
   input  logic [N_MASTERS*DATA_W/8-1:0]   m_wstrb,
   output logic [DATA_W-1:0]               m_rdata,
   output logic [N_MASTERS-1:0]            m_ready,
   output logic                            s_valid,
   output logic [ADDR_W-1:0]               s_addr,
   output logic [DATA_W-1:0]               s_wdata,
   output logic [DATA_W/8-1:0]             s_wstrb,
   input  logic [DATA_W-1:0]               s_rdata,
   input  logic                            s_ready,
   input  logic                            inv_req,
   output logic                            s_force_inv,
   output logic                            busy
);

   localparam int STRB_W = DATA_W / 8;
   localparam int IDX_W  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

   typedef enum logic {
      IDLE,
      BUSY
   } state_t;

   state_t             state;
   logic [IDX_W-1:0]   gnt_idx;
   logic [IDX_W-1:0]   last_idx;
   logic               inv_pend;
   logic [IDX_W-1:0]   next_idx;
   logic               any_req;

   // Round-robin pick: walk last_idx+N down to last_idx+1 so that the
   // closest requester after the previous winner is the last one written.
   always_comb begin
      next_idx = '0;
      any_req  = 1'b0;
      for (int k = N_MASTERS; k >= 1; k--) begin
         if (m_valid[IDX_W'((int'(last_idx) + k) % N_MASTERS)]) begin
            next_idx = IDX_W'((int'(last_idx) + k) % N_MASTERS);
            any_req  = 1'b1;
         end
      end
   end

   // The invalidate strobe fires only from IDLE, so it can never overlap a
   // cycle in which s_valid might be high.
   assign s_force_inv = (state == IDLE) && inv_pend;
   assign busy        = (state == BUSY) || inv_pend;
   assign m_rdata     = s_rdata;

   // Request routing from the granted master; everything is zero outside BUSY.
   always_comb begin
      s_valid = 1'b0;
      s_addr  = '0;
      s_wdata = '0;
      s_wstrb = '0;
      m_ready = '0;
      if (state == BUSY) begin
         s_valid          = m_valid[gnt_idx];
         s_addr           = m_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
         s_wdata          = m_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
         s_wstrb          = m_wstrb[int'(gnt_idx)*STRB_W +: STRB_W];
         m_ready[gnt_idx] = s_ready;
      end
   end

   // Grant FSM and invalidate latch. A fresh inv_req blocks the grant in the
   // same cycle, so an invalidate arriving together with a request goes first.
   // An inv_req seen while the strobe is being driven merges into that strobe.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         gnt_idx  <= '0;
         last_idx <= IDX_W'(N_MASTERS - 1);
         inv_pend <= 1'b0;
      end else begin
         if (s_force_inv) begin
            inv_pend <= 1'b0;
         end else if (inv_req) begin
            inv_pend <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (!inv_pend && !inv_req && any_req) begin
                  gnt_idx  <= next_idx;
                  last_idx <= next_idx;
                  state    <= BUSY;
               end
            end
            BUSY: begin
               if (s_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_l2_req_arbiter.sv
// tb_l2_req_arbiter
// Self-checking bench for l2_req_arbiter (N_MASTERS=2, 32-bit address/data).
// A transaction-level model (current owner, previous winner, pending
// invalidate) predicts every output each cycle; directed scenarios add
// literal expectations, followed by a randomized traffic phase.
module tb_l2_req_arbiter;

   localparam int N  = 2;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      m_valid;
   logic [N*AW-1:0]   m_addr;
   logic [N*DW-1:0]   m_wdata;
   logic [N*SW-1:0]   m_wstrb;
   logic [DW-1:0]     m_rdata;
   logic [N-1:0]      m_ready;
   logic              s_valid;
   logic [AW-1:0]     s_addr;
   logic [DW-1:0]     s_wdata;
   logic [SW-1:0]     s_wstrb;
   logic [DW-1:0]     s_rdata;
   logic              s_ready;
   logic              inv_req;
   logic              s_force_inv;
   logic              busy;

   int assertCount = 0;
   int failCount   = 0;

   // Model state: which master owns the L2 (-1 = none), the previous winner,
   // and whether an invalidate is still owed to the L2.
   int owner;
   int lastWin;
   bit invPend;
   int slaveLat;

   l2_req_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk         (clk),
      .rst         (rst),
      .m_valid     (m_valid),
      .m_addr      (m_addr),
      .m_wdata     (m_wdata),
      .m_wstrb     (m_wstrb),
      .m_rdata     (m_rdata),
      .m_ready     (m_ready),
      .s_valid     (s_valid),
      .s_addr      (s_addr),
      .s_wdata     (s_wdata),
      .s_wstrb     (s_wstrb),
      .s_rdata     (s_rdata),
      .s_ready     (s_ready),
      .inv_req     (inv_req),
      .s_force_inv (s_force_inv),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic resetModel();
      owner   = -1;
      lastWin = N - 1;
      invPend = 1'b0;
   endtask

   task automatic setMaster(input int i, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input logic [SW-1:0] strb);
      m_addr[i*AW +: AW]  = addr;
      m_wdata[i*DW +: DW] = wdata;
      m_wstrb[i*SW +: SW] = strb;
   endtask

   task automatic applyStimulus(input logic [N-1:0] valid, input logic inv, input logic ready);
      m_valid = valid;
      inv_req = inv;
      s_ready = ready;
      #1;
   endtask

   // Predict all outputs for the current cycle from the model and the inputs.
   task automatic checkOutput();
      logic          expValid;
      logic [AW-1:0] expAddr;
      logic [DW-1:0] expWdata;
      logic [SW-1:0] expStrb;
      logic [N-1:0]  expReady;
      expValid = 1'b0;
      expAddr  = '0;
      expWdata = '0;
      expStrb  = '0;
      expReady = '0;
      if (owner >= 0) begin
         expValid        = m_valid[owner];
         expAddr         = m_addr[owner*AW +: AW];
         expWdata        = m_wdata[owner*DW +: DW];
         expStrb         = m_wstrb[owner*SW +: SW];
         expReady[owner] = s_ready;
      end
      compare("model s_valid", s_valid, expValid);
      compare("model s_addr", s_addr, expAddr);
      compare("model s_wdata", s_wdata, expWdata);
      compare("model s_wstrb", s_wstrb, expStrb);
      compare("model m_ready", m_ready, expReady);
      compare("model m_rdata", m_rdata, s_rdata);
      compare("model s_force_inv", s_force_inv, (owner < 0) && invPend);
      compare("model busy", busy, (owner >= 0) || invPend);
   endtask

   // Advance the model across a clock edge using this cycle's inputs.
   task automatic updateModel();
      if (!rst) begin
         resetModel();
         return;
      end
      if (owner < 0) begin
         if (invPend) begin
            invPend = 1'b0;
         end else if (inv_req) begin
            invPend = 1'b1;
         end else if (m_valid != '0) begin
            for (int k = 1; k <= N; k++) begin
               int c;
               c = (lastWin + k) % N;
               if (m_valid[c]) begin
                  owner   = c;
                  lastWin = c;
                  break;
               end
            end
            slaveLat = $urandom_range(0, 4);
         end
      end else begin
         if (inv_req) invPend = 1'b1;
         if (s_ready) owner = -1;
      end
   endtask

   task automatic tick();
      checkOutput();
      @(posedge clk);
      updateModel();
      @(negedge clk);
   endtask

   initial begin
      logic [N-1:0] doneMask;
      rst      = 1'b0;
      m_valid  = '0;
      m_addr   = '0;
      m_wdata  = '0;
      m_wstrb  = '0;
      s_rdata  = '0;
      s_ready  = 1'b0;
      inv_req  = 1'b0;
      slaveLat = 0;
      resetModel();

      // Reset state
      @(negedge clk);
      applyStimulus('0, 1'b0, 1'b0);
      compare("reset s_valid", s_valid, 1'b0);
      compare("reset busy", busy, 1'b0);
      compare("reset s_force_inv", s_force_inv, 1'b0);
      tick();
      rst = 1'b1;
      applyStimulus('0, 1'b0, 1'b0);
      tick();

      // Contention: both masters always requesting, L2 answers one cycle later
      setMaster(0, 32'h0000_00A0, 32'h0, 4'h0);
      setMaster(1, 32'h0000_00B0, 32'h0, 4'h0);
      for (int t = 0; t < 4; t++) begin
         applyStimulus(2'b11, 1'b0, 1'b0);
         compare("contention idle gap", s_valid, 1'b0);
         tick();
         applyStimulus(2'b11, 1'b0, 1'b0);
         compare("contention s_valid", s_valid, 1'b1);
         compare("contention s_addr", s_addr, (t % 2 == 0) ? 32'hA0 : 32'hB0);
         tick();
         applyStimulus(2'b11, 1'b0, 1'b1);
         compare("contention m_ready", m_ready, (t % 2 == 0) ? 2'b01 : 2'b10);
         tick();
      end
      applyStimulus('0, 1'b0, 1'b0);
      tick();

      // Single read from master 0, L2 answers three cycles after the request
      setMaster(0, 32'h0000_0100, 32'h0, 4'h0);
      applyStimulus(2'b01, 1'b0, 1'b0);
      compare("single s_valid before grant", s_valid, 1'b0);
      tick();
      applyStimulus(2'b01, 1'b0, 1'b0);
      compare("single s_valid", s_valid, 1'b1);
      compare("single s_addr", s_addr, 32'h100);
      tick();
      applyStimulus(2'b01, 1'b0, 1'b0);
      compare("single m_ready early", m_ready, 2'b00);
      tick();
      s_rdata = 32'hDEAD_BEEF;
      applyStimulus(2'b01, 1'b0, 1'b1);
      compare("single m_ready", m_ready, 2'b01);
      compare("single m_rdata", m_rdata, 32'hDEAD_BEEF);
      tick();
      applyStimulus('0, 1'b0, 1'b0);
      compare("single s_valid after done", s_valid, 1'b0);
      tick();

      // Write routing from master 1 while master 0 holds different fields
      setMaster(0, 32'h0000_0999, 32'h0000_AAAA, 4'h3);
      setMaster(1, 32'h0000_0020, 32'h1234_5678, 4'hF);
      applyStimulus(2'b10, 1'b0, 1'b0);
      tick();
      applyStimulus(2'b10, 1'b0, 1'b1);
      compare("write s_addr", s_addr, 32'h20);
      compare("write s_wdata", s_wdata, 32'h1234_5678);
      compare("write s_wstrb", s_wstrb, 4'hF);
      compare("write m_ready", m_ready, 2'b10);
      tick();
      applyStimulus('0, 1'b0, 1'b0);
      tick();

      // Invalidate pulses during a five-cycle L2 access merge into one strobe
      setMaster(0, 32'h0000_0040, 32'h0, 4'h0);
      applyStimulus(2'b01, 1'b0, 1'b0);
      tick();
      applyStimulus(2'b01, 1'b0, 1'b0);
      tick();
      for (int p = 0; p < 3; p++) begin
         applyStimulus(2'b01, 1'b1, 1'b0);
         compare("inv-busy no strobe", s_force_inv, 1'b0);
         tick();
      end
      applyStimulus(2'b01, 1'b0, 1'b1);
      compare("inv-busy strobe at ready", s_force_inv, 1'b0);
      compare("inv-busy m_ready", m_ready, 2'b01);
      tick();
      applyStimulus('0, 1'b0, 1'b0);
      compare("inv-busy strobe", s_force_inv, 1'b1);
      compare("inv-busy s_valid in strobe", s_valid, 1'b0);
      tick();
      applyStimulus('0, 1'b0, 1'b0);
      compare("inv-busy single strobe", s_force_inv, 1'b0);
      tick();

      // Invalidate and request together while idle: strobe first, then grant
      applyStimulus(2'b01, 1'b1, 1'b0);
      compare("inv-prio strobe at t", s_force_inv, 1'b0);
      tick();
      applyStimulus(2'b01, 1'b0, 1'b0);
      compare("inv-prio strobe", s_force_inv, 1'b1);
      compare("inv-prio s_valid in strobe", s_valid, 1'b0);
      tick();
      applyStimulus(2'b01, 1'b0, 1'b0);
      compare("inv-prio strobe once", s_force_inv, 1'b0);
      tick();
      applyStimulus(2'b01, 1'b0, 1'b1);
      compare("inv-prio s_valid", s_valid, 1'b1);
      compare("inv-prio m_ready", m_ready, 2'b01);
      tick();
      applyStimulus('0, 1'b0, 1'b0);
      tick();

      // Randomized traffic against the model
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int i = 0; i < N; i++) begin
            if (!m_valid[i] && $urandom_range(0, 2) == 0) begin
               m_valid[i] = 1'b1;
               setMaster(i, $urandom, $urandom, SW'($urandom_range(0, 15)));
            end
         end
         inv_req = ($urandom_range(0, 9) == 0);
         s_ready = (owner >= 0) && (slaveLat == 0);
         s_rdata = $urandom;
         #1;
         doneMask = '0;
         if (owner >= 0) begin
            if (s_ready) doneMask[owner] = 1'b1;
            else if (slaveLat > 0) slaveLat--;
         end
         tick();
         m_valid = m_valid & ~doneMask;
      end

      // Drain outstanding work
      for (int d = 0; d < 10; d++) begin
         inv_req = 1'b0;
         s_ready = (owner >= 0);
         m_valid = (owner >= 0) ? (m_valid & (N'(1) << owner)) : '0;
         #1;
         doneMask = '0;
         if (owner >= 0) doneMask[owner] = 1'b1;
         tick();
         m_valid = m_valid & ~doneMask;
      end

      // Asynchronous reset in the middle of a transaction
      setMaster(0, 32'h0000_0300, 32'h0, 4'h0);
      setMaster(1, 32'h0000_0310, 32'h0, 4'h0);
      applyStimulus(2'b10, 1'b0, 1'b0);
      tick();
      applyStimulus(2'b10, 1'b1, 1'b1);
      compare("areset m_ready before", m_ready, 2'b10);
      rst = 1'b0;
      #1;
      compare("areset s_valid", s_valid, 1'b0);
      compare("areset m_ready", m_ready, 2'b00);
      compare("areset busy", busy, 1'b0);
      resetModel();
      tick();
      applyStimulus(2'b11, 1'b0, 1'b0);
      tick();
      rst = 1'b1;
      applyStimulus(2'b11, 1'b0, 1'b0);
      tick();
      applyStimulus(2'b11, 1'b0, 1'b0);
      compare("areset first grant valid", s_valid, 1'b1);
      compare("areset first grant addr", s_addr, 32'h300);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
